mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multi-cycle control FSM for the MIPS datapath: sequences FETCH/DECODE/EXE/MEM/WB over the shared ALU, regfile, NPC and memory.
//  Decodes the same ISA subset and control encodings as the single-cycle controller, but asserts each strobe only in its stage.
//  Stalls on a memory ready handshake. Counts retired instructions.
// PARAMETERS
//  MEM_HANDSHAKE  1   1: FETCH/MEM wait for mem_ready; 0: each memory access takes exactly one cycle
//  CNT_W          32  width of retired-instruction counter
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-high
//  op         in   6   IR[31:26], stable from the cycle after IRWrite
//  func       in   6   IR[5:0]
//  rt         in   5   IR[20:16], REGIMM sub-op (bltz/bgez/bltzal/bgezal)
//  Zero,NE,G_E,G,L_E,L in 1 each  comparator flags, valid in EXE
//  mem_ready  in   1   memory access done this cycle (ignored if MEM_HANDSHAKE=0)
//  IRWrite    out  1   load IR
//  PCWrite    out  1   load PC from NPC; exactly one pulse per instruction
//  NPCOp      out  3   000 PC+4, 001 branch, 010 j, 011 jal, 100 jr
//  ALUOp      out  3   000 add, 001 sub, 010 or, 011 slt, 100 srlv, 101 srl
//  EXTOp      out  2   00 zero, 01 lui, 10 sign
//  ALUSrc     out  1   1: immediate operand
//  RegDst     out  2   00 rt, 01 rd, 10 $31
//  MemtoReg   out  2   00 ALU, 01 mem, 10 PC+4, 11 compare result
//  RegWrite, MemRead, MemWrite  out 1 each
//  illegal    out  1   one-cycle pulse in DECODE on unknown opcode/funct
//  state      out  3   current FSM state (debug)
//  instr_cnt  out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - Reset: state=FETCH, instr_cnt=0; while reset high all strobes (IRWrite,PCWrite,RegWrite,MemRead,MemWrite,illegal) forced 0.
//  - Outputs are combinational from state, op, func, rt and flags; state and counter are registered.
//  - FETCH: MemRead=1. Leave when mem_ready=1 (or after 1 cycle if MEM_HANDSHAKE=0); IRWrite=1 in that cycle only.
//  - DECODE: regfile read, EXTOp valid.
//    * j/jr: PCWrite, NPCOp=010/100 -> FETCH.
//    * jal: PCWrite, NPCOp=011, RegWrite, RegDst=10, MemtoReg=10 -> FETCH.
//    * unknown: illegal=1, PCWrite, NPCOp=000 -> FETCH (executed as nop).
//    * all others -> EXE.
//  - EXE: ALUOp/ALUSrc driven.
//    * branches: PCWrite, NPCOp=001 if taken else 000 -> FETCH.
//      Taken conditions: beq&Zero, bne&NE, bgtz&G, blez&L_E, bltz/bltzal&L, bgez/bgezal&G_E.
//    * bltzal/bgezal: RegWrite, RegDst=10, MemtoReg=10 regardless of taken.
//    * lw/sw -> MEM; R-type, ori, lui, slti, sltiu -> WB.
//  - MEM: MemRead (lw) or MemWrite (sw), held high until mem_ready.
//    * sw: PCWrite in the ready cycle -> FETCH.
//    * lw -> WB.
//  - WB: RegWrite, PCWrite, NPCOp=000 -> FETCH.
//    * RegDst: 01 R-type, 00 otherwise.
//    * MemtoReg: 01 lw, 11 slt/sltu/slti/sltiu, 00 others.
//  - Latency in cycles (MEM_HANDSHAKE=0): j/jal/jr 2, branch 3, ALU ops 4, sw 4, lw 5.
//    Each wait cycle adds one.
//  - instr_cnt increments on every PCWrite and wraps modulo 2^CNT_W.
//  - Reset mid-MEM: pending MemWrite is dropped in the reset cycle; next state is FETCH.
//  - mem_ready high outside FETCH/MEM is ignored.
//  - Encodings 5-7 of state are unreachable; if entered, next state is FETCH with no strobes asserted.
// STRUCTURE
//  - Package mc_pkg: opcode/funct/rt constants, state encoding (FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4),
//    NPCOp/ALUOp/EXTOp/RegDst/MemtoReg localparams.
//  - Sub-module mc_decode: combinational op/func/rt -> one-hot instruction class plus illegal.
//  - FSM, strobe generation and counter live in mc_controller.
// TESTING
//  - Reset held 3 cycles, then released, mem_ready=1: state 0->1; IRWrite in cycle 1 only; no RegWrite/MemWrite during reset.
//  - addu (op=0, func=0x21), MEM_HANDSHAKE=0: states 0,1,2,4; RegWrite=1, RegDst=01, PCWrite only in WB; instr_cnt=1.
//  - lw (op=0x23) with mem_ready low 2 cycles in MEM: MemRead held 3 cycles; WB MemtoReg=01; total 7 cycles.
//  - beq (op=0x04): Zero=1 -> EXE PCWrite with NPCOp=001; Zero=0 -> NPCOp=000; both return to FETCH.
//  - bgezal (op=1, rt=0x11) with G_E=0: RegWrite, RegDst=10, MemtoReg=10, NPCOp=000.
//    Then op=0x3F: illegal pulse, PCWrite, instr_cnt+1.
//  - sw (op=0x2B), reset asserted in MEM: MemWrite=0 that cycle; next state FETCH; instr_cnt=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller.
// Holds the FSM state encoding, the ISA opcode/funct/rt constants,
// the datapath control encodings and the decoded-instruction struct.
package mc_pkg;

  // FSM state encoding (3 bits; 5..7 unused)
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXE    = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  // Primary opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  // R-type funct codes, IR[5:0]
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  // REGIMM sub-ops, IR[20:16]
  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  // Next-PC select
  localparam logic [2:0] NPC_PC4 = 3'b000;
  localparam logic [2:0] NPC_BR  = 3'b001;
  localparam logic [2:0] NPC_J   = 3'b010;
  localparam logic [2:0] NPC_JAL = 3'b011;
  localparam logic [2:0] NPC_JR  = 3'b100;

  // ALU operation
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_SRLV = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;

  // Immediate extension
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_LUI  = 2'b01;
  localparam logic [1:0] EXT_SIGN = 2'b10;

  // Register destination and write-back source
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;
  localparam logic [1:0] M2R_CMP = 2'b11;

  // Branch condition select (which comparator flag decides "taken")
  localparam logic [2:0] BR_EQ  = 3'd0;
  localparam logic [2:0] BR_NE  = 3'd1;
  localparam logic [2:0] BR_GTZ = 3'd2;
  localparam logic [2:0] BR_LEZ = 3'd3;
  localparam logic [2:0] BR_LTZ = 3'd4;
  localparam logic [2:0] BR_GEZ = 3'd5;

  // One-hot instruction class; all zero for an illegal instruction
  typedef struct packed {
    logic alu_r;   // R-type ALU op -> WB
    logic alu_i;   // ori/lui/slti/sltiu -> WB
    logic load;
    logic store;
    logic branch;
    logic j;
    logic jal;
    logic jr;
  } cls_t;

  typedef struct packed {
    cls_t       cls;
    logic       illegal;
    logic       link;     // bltzal/bgezal: write PC+4 to $31
    logic       cmp_res;  // slt family: write-back takes compare result
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] ext_op;
    logic [2:0] br_cond;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder.
// Ports: op/func/rt (instruction fields) in; dec (class + ALU/EXT
// controls + illegal flag) out.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic [4:0] rt,
  output dec_t       dec
);

  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    dec.ext_op = EXT_SIGN;
    case (op)
      OP_RTYPE: begin
        dec.cls.alu_r = 1'b1;
        case (func)
          F_ADDU: dec.alu_op = ALU_ADD;
          F_SUBU: dec.alu_op = ALU_SUB;
          F_OR:   dec.alu_op = ALU_OR;
          F_SLT, F_SLTU: begin
            dec.alu_op  = ALU_SLT;
            dec.cmp_res = 1'b1;
          end
          F_SRLV: dec.alu_op = ALU_SRLV;
          F_SRL:  dec.alu_op = ALU_SRL;
          F_JR: begin
            dec.cls.alu_r = 1'b0;
            dec.cls.jr    = 1'b1;
          end
          default: begin
            dec.cls.alu_r = 1'b0;
            dec.illegal   = 1'b1;
          end
        endcase
      end
      OP_REGIMM: begin
        dec.alu_op     = ALU_SUB;
        dec.cls.branch = 1'b1;
        case (rt)
          RT_BLTZ:   dec.br_cond = BR_LTZ;
          RT_BGEZ:   dec.br_cond = BR_GEZ;
          RT_BLTZAL: begin dec.br_cond = BR_LTZ; dec.link = 1'b1; end
          RT_BGEZAL: begin dec.br_cond = BR_GEZ; dec.link = 1'b1; end
          default: begin
            dec.cls.branch = 1'b0;
            dec.illegal    = 1'b1;
          end
        endcase
      end
      OP_BEQ:  begin dec.cls.branch = 1'b1; dec.alu_op = ALU_SUB; dec.br_cond = BR_EQ;  end
      OP_BNE:  begin dec.cls.branch = 1'b1; dec.alu_op = ALU_SUB; dec.br_cond = BR_NE;  end
      OP_BGTZ: begin dec.cls.branch = 1'b1; dec.alu_op = ALU_SUB; dec.br_cond = BR_GTZ; end
      OP_BLEZ: begin dec.cls.branch = 1'b1; dec.alu_op = ALU_SUB; dec.br_cond = BR_LEZ; end
      OP_ORI: begin
        dec.cls.alu_i = 1'b1; dec.alu_op = ALU_OR; dec.alu_src = 1'b1; dec.ext_op = EXT_ZERO;
      end
      // lui: extender does the shift, ALU ORs it with rs (encoded as $0)
      OP_LUI: begin
        dec.cls.alu_i = 1'b1; dec.alu_op = ALU_OR; dec.alu_src = 1'b1; dec.ext_op = EXT_LUI;
      end
      OP_SLTI, OP_SLTIU: begin
        dec.cls.alu_i = 1'b1; dec.alu_op = ALU_SLT; dec.alu_src = 1'b1; dec.cmp_res = 1'b1;
      end
      OP_LW:  begin dec.cls.load  = 1'b1; dec.alu_src = 1'b1; end
      OP_SW:  begin dec.cls.store = 1'b1; dec.alu_src = 1'b1; end
      OP_J:   dec.cls.j   = 1'b1;
      OP_JAL: dec.cls.jal = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: FETCH -> DECODE -> EXE -> MEM -> WB.
// Inputs: clk, reset (sync, active-high), op/func/rt instruction fields,
// comparator flags (valid in EXE), mem_ready memory handshake.
// Outputs: datapath strobes (IRWrite, PCWrite, RegWrite, MemRead,
// MemWrite), selects (NPCOp, ALUOp, EXTOp, ALUSrc, RegDst, MemtoReg),
// illegal pulse, debug state and retired-instruction count instr_cnt.
// Handshake: a memory access (FETCH read, MEM read/write) is issued by
// holding MemRead/MemWrite high; it completes in the cycle mem_ready is
// high, and only then does the FSM advance. mem_ready is ignored in every
// other state, and entirely when MEM_HANDSHAKE=0 (one-cycle accesses).
module mc_controller
  import mc_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic [4:0]       rt,
  input  logic             Zero,
  input  logic             NE,
  input  logic             G_E,
  input  logic             G,
  input  logic             L_E,
  input  logic             L,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [2:0]       NPCOp,
  output logic [2:0]       ALUOp,
  output logic [1:0]       EXTOp,
  output logic             ALUSrc,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  dec_t       dec;
  logic       rdy;
  logic       taken;
  logic [2:0] next_state;
  logic       ir_w, pc_w, reg_w, mem_r, mem_w, ill;

  mc_decode u_decode (
    .op   (op),
    .func (func),
    .rt   (rt),
    .dec  (dec)
  );

  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_comb begin
    case (dec.br_cond)
      BR_EQ:   taken = Zero;
      BR_NE:   taken = NE;
      BR_GTZ:  taken = G;
      BR_LEZ:  taken = L_E;
      BR_LTZ:  taken = L;
      BR_GEZ:  taken = G_E;
      default: taken = 1'b0;
    endcase
  end

  // Selects are pure functions of the decoded instruction; only the
  // strobes and NPCOp depend on the state.
  assign ALUOp  = dec.alu_op;
  assign EXTOp  = dec.ext_op;
  assign ALUSrc = dec.alu_src;
  assign RegDst = (dec.cls.jal || dec.link) ? DST_RA :
                  dec.cls.alu_r             ? DST_RD : DST_RT;
  assign MemtoReg = (dec.cls.jal || dec.link) ? M2R_PC4 :
                    dec.cls.load              ? M2R_MEM :
                    dec.cmp_res               ? M2R_CMP : M2R_ALU;

  always_comb begin
    next_state = state;
    ir_w  = 1'b0;
    pc_w  = 1'b0;
    reg_w = 1'b0;
    mem_r = 1'b0;
    mem_w = 1'b0;
    ill   = 1'b0;
    NPCOp = NPC_PC4;
    case (state)
      S_FETCH: begin
        mem_r = 1'b1;
        if (rdy) begin
          ir_w       = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        next_state = S_FETCH;
        if (dec.illegal) begin
          ill  = 1'b1;
          pc_w = 1'b1;
        end else if (dec.cls.j) begin
          pc_w  = 1'b1;
          NPCOp = NPC_J;
        end else if (dec.cls.jr) begin
          pc_w  = 1'b1;
          NPCOp = NPC_JR;
        end else if (dec.cls.jal) begin
          pc_w  = 1'b1;
          reg_w = 1'b1;
          NPCOp = NPC_JAL;
        end else begin
          next_state = S_EXE;
        end
      end
      S_EXE: begin
        if (dec.cls.branch) begin
          pc_w       = 1'b1;
          reg_w      = dec.link;
          NPCOp      = taken ? NPC_BR : NPC_PC4;
          next_state = S_FETCH;
        end else if (dec.cls.load || dec.cls.store) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        mem_w = dec.cls.store;
        mem_r = ~dec.cls.store;
        if (rdy) begin
          pc_w       = dec.cls.store;
          next_state = dec.cls.store ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        reg_w      = 1'b1;
        pc_w       = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Reset masks every strobe so a pending access or write is dropped.
  assign IRWrite  = ir_w  & ~reset;
  assign PCWrite  = pc_w  & ~reset;
  assign RegWrite = reg_w & ~reset;
  assign MemRead  = mem_r & ~reset;
  assign MemWrite = mem_w & ~reset;
  assign illegal  = ill   & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      instr_cnt <= '0;
    end else begin
      state <= next_state;
      if (pc_w) instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller. One DUT with the memory handshake
// enabled, one with it disabled, sharing all inputs.
module tb_mc_controller;

  logic        clk, reset;
  logic [5:0]  op, func;
  logic [4:0]  rt;
  logic        Zero, NE, G_E, G, L_E, L, mem_ready;

  logic        IRWrite, PCWrite, ALUSrc, RegWrite, MemRead, MemWrite, illegal;
  logic [2:0]  NPCOp, ALUOp, state;
  logic [1:0]  EXTOp, RegDst, MemtoReg;
  logic [31:0] instr_cnt;

  logic        z_irw, z_pcw, z_alusrc, z_rw, z_mr, z_mw, z_ill;
  logic [2:0]  z_npc, z_aluop, z_state;
  logic [1:0]  z_ext, z_dst, z_m2r;
  logic [31:0] z_cnt;

  logic [5:0]  strb;
  assign strb = {IRWrite, PCWrite, RegWrite, MemRead, MemWrite, illegal};

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  // expected per-cycle entry: {state, strobes, NPCOp, RegDst, MemtoReg}
  logic [15:0] exp_q[$];

  mc_controller #(.MEM_HANDSHAKE(1'b1), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .rt(rt),
    .Zero(Zero), .NE(NE), .G_E(G_E), .G(G), .L_E(L_E), .L(L),
    .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .NPCOp(NPCOp), .ALUOp(ALUOp),
    .EXTOp(EXTOp), .ALUSrc(ALUSrc), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .illegal(illegal), .state(state), .instr_cnt(instr_cnt)
  );

  mc_controller #(.MEM_HANDSHAKE(1'b0), .CNT_W(32)) u_dut0 (
    .clk(clk), .reset(reset), .op(op), .func(func), .rt(rt),
    .Zero(Zero), .NE(NE), .G_E(G_E), .G(G), .L_E(L_E), .L(L),
    .mem_ready(mem_ready),
    .IRWrite(z_irw), .PCWrite(z_pcw), .NPCOp(z_npc), .ALUOp(z_aluop),
    .EXTOp(z_ext), .ALUSrc(z_alusrc), .RegDst(z_dst), .MemtoReg(z_m2r),
    .RegWrite(z_rw), .MemRead(z_mr), .MemWrite(z_mw),
    .illegal(z_ill), .state(z_state), .instr_cnt(z_cnt)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ent(input logic [2:0] st, input logic [5:0] s,
                                      input logic [2:0] n, input logic [1:0] d,
                                      input logic [1:0] m);
    return {st, s, n, d, m};
  endfunction

  // Pop one expected entry, compare this cycle's outputs, advance a cycle.
  task automatic step_chk(input string tag);
    logic [15:0] e;
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got empty expected queue required an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".state"},  32'(state),    32'(e[15:13]));
      chk({tag, ".strobe"}, 32'(strb),     32'(e[12:7]));
      chk({tag, ".npc"},    32'(NPCOp),    32'(e[6:4]));
      chk({tag, ".dst"},    32'(RegDst),   32'(e[3:2]));
      chk({tag, ".m2r"},    32'(MemtoReg), 32'(e[1:0]));
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; op = 6'h2b; func = 6'h00; rt = 5'h00; mem_ready = 1'b1;
    Zero = 1'b0; NE = 1'b0; G_E = 1'b0; G = 1'b0; L_E = 1'b0; L = 1'b0;

    // reset held 3 cycles: FETCH, no strobes
    repeat (3) begin
      tick();
      chk("rst.state",  32'(state), 32'd0);
      chk("rst.strobe", 32'(strb),  32'd0);
      chk("rst.cnt",    instr_cnt,  32'd0);
    end
    reset = 1'b0;

    // addu: F D E W
    op = 6'h00; func = 6'h21;
    exp_q.push_back(ent(3'd0, 6'b100100, 3'b000, 2'b01, 2'b00));
    exp_q.push_back(ent(3'd1, 6'b000000, 3'b000, 2'b01, 2'b00));
    exp_q.push_back(ent(3'd2, 6'b000000, 3'b000, 2'b01, 2'b00));
    exp_q.push_back(ent(3'd4, 6'b011000, 3'b000, 2'b01, 2'b00));
    step_chk("addu.f"); step_chk("addu.d");
    chk("addu.aluop", 32'(ALUOp), 32'd0);
    step_chk("addu.e"); step_chk("addu.w");
    exp_cnt = 1;
    chk("addu.cnt", instr_cnt, 32'(exp_cnt));

    // lw with two wait cycles in MEM: 7 cycles
    op = 6'h23; func = 6'h00;
    exp_q.push_back(ent(3'd0, 6'b100100, 3'b000, 2'b00, 2'b01));
    exp_q.push_back(ent(3'd1, 6'b000000, 3'b000, 2'b00, 2'b01));
    exp_q.push_back(ent(3'd2, 6'b000000, 3'b000, 2'b00, 2'b01));
    repeat (3) exp_q.push_back(ent(3'd3, 6'b000100, 3'b000, 2'b00, 2'b01));
    exp_q.push_back(ent(3'd4, 6'b011000, 3'b000, 2'b00, 2'b01));
    step_chk("lw.f");
    mem_ready = 1'b0;
    step_chk("lw.d");
    chk("lw.alusrc", 32'(ALUSrc), 32'd1);
    chk("lw.extop",  32'(EXTOp),  32'd2);
    step_chk("lw.e"); step_chk("lw.m0"); step_chk("lw.m1");
    mem_ready = 1'b1;
    step_chk("lw.m2"); step_chk("lw.w");
    exp_cnt = 2;
    chk("lw.cnt", instr_cnt, 32'(exp_cnt));

    // beq taken, then not taken
    op = 6'h04; Zero = 1'b1;
    exp_q.push_back(ent(3'd0, 6'b100100, 3'b000, 2'b00, 2'b00));
    exp_q.push_back(ent(3'd1, 6'b000000, 3'b000, 2'b00, 2'b00));
    exp_q.push_back(ent(3'd2, 6'b010000, 3'b001, 2'b00, 2'b00));
    step_chk("beqt.f"); step_chk("beqt.d"); step_chk("beqt.e");
    exp_cnt = 3;
    chk("beqt.cnt", instr_cnt, 32'(exp_cnt));
    Zero = 1'b0;
    exp_q.push_back(ent(3'd0, 6'b100100, 3'b000, 2'b00, 2'b00));
    exp_q.push_back(ent(3'd1, 6'b000000, 3'b000, 2'b00, 2'b00));
    exp_q.push_back(ent(3'd2, 6'b010000, 3'b000, 2'b00, 2'b00));
    step_chk("beqn.f"); step_chk("beqn.d"); step_chk("beqn.e");
    exp_cnt = 4;

    // bgezal not taken: still links
    op = 6'h01; rt = 5'h11; G_E = 1'b0; L = 1'b1;
    exp_q.push_back(ent(3'd0, 6'b100100, 3'b000, 2'b10, 2'b10));
    exp_q.push_back(ent(3'd1, 6'b000000, 3'b000, 2'b10, 2'b10));
    exp_q.push_back(ent(3'd2, 6'b011000, 3'b000, 2'b10, 2'b10));
    step_chk("bgezal.f"); step_chk("bgezal.d"); step_chk("bgezal.e");
    exp_cnt = 5;
    chk("bgezal.cnt", instr_cnt, 32'(exp_cnt));
    L = 1'b0; rt = 5'h00;

    // illegal opcode: executed as nop from DECODE
    op = 6'h3f;
    exp_q.push_back(ent(3'd0, 6'b100100, 3'b000, 2'b00, 2'b00));
    exp_q.push_back(ent(3'd1, 6'b010001, 3'b000, 2'b00, 2'b00));
    step_chk("ill.f"); step_chk("ill.d");
    exp_cnt = 6;
    chk("ill.cnt", instr_cnt, 32'(exp_cnt));

    // jal, j, jr: two cycles each
    op = 6'h03;
    exp_q.push_back(ent(3'd0, 6'b100100, 3'b000, 2'b10, 2'b10));
    exp_q.push_back(ent(3'd1, 6'b011000, 3'b011, 2'b10, 2'b10));
    step_chk("jal.f"); step_chk("jal.d");
    op = 6'h02;
    exp_q.push_back(ent(3'd0, 6'b100100, 3'b000, 2'b00, 2'b00));
    exp_q.push_back(ent(3'd1, 6'b010000, 3'b010, 2'b00, 2'b00));
    step_chk("j.f"); step_chk("j.d");
    op = 6'h00; func = 6'h08;
    exp_q.push_back(ent(3'd0, 6'b100100, 3'b000, 2'b00, 2'b00));
    exp_q.push_back(ent(3'd1, 6'b010000, 3'b100, 2'b00, 2'b00));
    step_chk("jr.f"); step_chk("jr.d");
    exp_cnt = 9;
    chk("jump.cnt", instr_cnt, 32'(exp_cnt));

    // slti: compare result write-back
    op = 6'h0a; func = 6'h00;
    exp_q.push_back(ent(3'd0, 6'b100100, 3'b000, 2'b00, 2'b11));
    exp_q.push_back(ent(3'd1, 6'b000000, 3'b000, 2'b00, 2'b11));
    exp_q.push_back(ent(3'd2, 6'b000000, 3'b000, 2'b00, 2'b11));
    exp_q.push_back(ent(3'd4, 6'b011000, 3'b000, 2'b00, 2'b11));
    step_chk("slti.f"); step_chk("slti.d");
    chk("slti.aluop", 32'(ALUOp), 32'd3);
    step_chk("slti.e"); step_chk("slti.w");
    exp_cnt = 10;

    // sw: PCWrite with MemWrite in the ready cycle
    op = 6'h2b;
    exp_q.push_back(ent(3'd0, 6'b100100, 3'b000, 2'b00, 2'b00));
    exp_q.push_back(ent(3'd1, 6'b000000, 3'b000, 2'b00, 2'b00));
    exp_q.push_back(ent(3'd2, 6'b000000, 3'b000, 2'b00, 2'b00));
    exp_q.push_back(ent(3'd3, 6'b010010, 3'b000, 2'b00, 2'b00));
    step_chk("sw.f"); step_chk("sw.d"); step_chk("sw.e"); step_chk("sw.m");
    exp_cnt = 11;
    chk("sw.cnt", instr_cnt, 32'(exp_cnt));

    // sw with reset asserted in MEM: write dropped, back to FETCH, count cleared
    exp_q.push_back(ent(3'd0, 6'b100100, 3'b000, 2'b00, 2'b00));
    exp_q.push_back(ent(3'd1, 6'b000000, 3'b000, 2'b00, 2'b00));
    exp_q.push_back(ent(3'd2, 6'b000000, 3'b000, 2'b00, 2'b00));
    step_chk("swr.f"); step_chk("swr.d"); step_chk("swr.e");
    reset = 1'b1;
    exp_q.push_back(ent(3'd3, 6'b000000, 3'b000, 2'b00, 2'b00));
    step_chk("swr.m");
    chk("swr.state", 32'(state), 32'd0);
    chk("swr.cnt",   instr_cnt,  32'd0);
    reset = 1'b0;
    exp_q.push_back(ent(3'd0, 6'b100100, 3'b000, 2'b00, 2'b00));
    step_chk("swr.f2");

    // MEM_HANDSHAKE=0 instance ignores mem_ready; handshake instance stalls
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_ready = 1'b0; op = 6'h00; func = 6'h21;
    begin
      logic [2:0] exp_st [5];
      exp_st = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
      for (int i = 0; i < 5; i++) begin
        #1;
        chk("mh0.state",  32'(z_state), 32'(exp_st[i]));
        chk("stall.state", 32'(state),  32'd0);
        chk("stall.irw",  32'(IRWrite), 32'd0);
        tick();
      end
    end
    chk("mh0.cnt",   z_cnt,     32'd1);
    chk("stall.cnt", instr_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
